// File: rtl/rx_frame_fifo_buff.sv
// Frame-aware receive byte FIFO: buffers MAC payload bytes with an end-of-frame
// tag per entry and reports whether at least one complete frame is held.
module rx_frame_fifo_buff #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 11,
  parameter int CNT_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rx_mac_last,
  input  logic              read,
  output logic [DATA_W-1:0] data_out,
  output logic              empty,
  output logic              full,
  output logic              tx_valid_flag
);

  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(1 << ADDR_W);

  // Strobe semantics: a read is taken when read=1 and the FIFO is not empty;
  // a write is taken when write=1 and the FIFO is not full, or a read is taken
  // in the same cycle. Untaken strobes are dropped without side effects.
  logic [DATA_W:0]   mem [2**ADDR_W];
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [CNT_W-1:0]  occ;
  logic [CNT_W-1:0]  frames;
  logic [DATA_W:0]   rd_entry;
  logic              rd_ok;
  logic              wr_ok;
  logic              frame_in;
  logic              frame_out;

  assign empty         = (occ == '0);
  assign full          = (occ == DEPTH);
  assign tx_valid_flag = (frames != '0);

  assign rd_entry  = mem[rptr];
  assign rd_ok     = read && !empty;
  assign wr_ok     = write && (!full || rd_ok);
  assign frame_in  = wr_ok && rx_mac_last;
  assign frame_out = rd_ok && rd_entry[DATA_W];

  // Storage is never cleared; reset only blocks the write in its cycle.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) begin
      mem[wptr] <= {rx_mac_last, data_in};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      occ      <= '0;
      frames   <= '0;
      data_out <= '0;
    end else begin
      if (rd_ok) begin
        data_out <= rd_entry[DATA_W-1:0];
        rptr     <= rptr + ADDR_W'(1);
      end
      if (wr_ok) begin
        wptr <= wptr + ADDR_W'(1);
      end
      case ({wr_ok, rd_ok})
        2'b10:   occ <= occ + CNT_W'(1);
        2'b01:   occ <= occ - CNT_W'(1);
        default: occ <= occ;
      endcase
      if (frame_in && !frame_out && frames != DEPTH) begin
        frames <= frames + CNT_W'(1);
      end else if (frame_out && !frame_in && frames != '0) begin
        frames <= frames - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_rx_frame_fifo_buff.sv
// Randomised and directed bench for rx_frame_fifo_buff against a queue model;
// read data is checked by a separate monitor from an expected-byte queue.
module tb_rx_frame_fifo_buff;

  localparam int DEPTH = 2048;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       write = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       rx_mac_last = 1'b0;
  logic       read = 1'b0;
  logic [7:0] data_out;
  logic       empty;
  logic       full;
  logic       tx_valid_flag;

  rx_frame_fifo_buff dut (
    .clk           (clk),
    .rst           (rst),
    .write         (write),
    .data_in       (data_in),
    .rx_mac_last   (rx_mac_last),
    .read          (read),
    .data_out      (data_out),
    .empty         (empty),
    .full          (full),
    .tx_valid_flag (tx_valid_flag)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  logic [8:0] model_q[$];
  logic [7:0] exp_q[$];
  logic       rd_seen = 1'b0;
  logic       mon_en = 1'b0;
  logic [7:0] last_data = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_has_frame();
    for (int i = 0; i < model_q.size(); i++) begin
      if (model_q[i][8]) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic check_flags(input string tag);
    check({tag, " empty"}, 32'(empty), 32'(model_q.size() == 0));
    check({tag, " full"},  32'(full),  32'(model_q.size() == DEPTH));
    check({tag, " tx_valid_flag"}, 32'(tx_valid_flag), 32'(model_has_frame()));
  endtask

  // driver: one clock of stimulus, model update at the edge, flag check after it
  task automatic cycle(input logic w, input logic [7:0] d, input logic l, input logic r);
    bit         rd_acc;
    bit         wr_acc;
    logic [8:0] e;
    write = w; data_in = d; rx_mac_last = l; read = r;
    @(posedge clk);
    rd_acc = r && (model_q.size() > 0);
    wr_acc = w && ((model_q.size() < DEPTH) || rd_acc);
    if (rd_acc) begin
      e = model_q.pop_front();
      exp_q.push_back(e[7:0]);
    end
    if (wr_acc) model_q.push_back({l, d});
    rd_seen = rd_acc;
    #1;
    check_flags("cycle");
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    rst = 1'b1; write = 1'b1; read = 1'b1; data_in = 8'hEE; rx_mac_last = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_q.delete();
    exp_q.delete();
    rd_seen = 1'b0;
    last_data = 8'h00;
    check("reset empty", 32'(empty), 32'd1);
    check("reset full", 32'(full), 32'd0);
    check("reset tx_valid_flag", 32'(tx_valid_flag), 32'd0);
    check("reset data_out", 32'(data_out), 32'h00);
    rst = 1'b0; write = 1'b0; read = 1'b0; rx_mac_last = 1'b0;
    mon_en = 1'b1;
  endtask

  // scoreboard monitor: pops on every accepted read, otherwise data_out must hold
  always @(negedge clk) begin
    if (mon_en) begin
      if (rd_seen) begin
        if (exp_q.size() == 0) begin
          check("monitor exp_q underflow", 32'd1, 32'd0);
        end else begin
          last_data = exp_q.pop_front();
          check("read data", 32'(data_out), 32'(last_data));
        end
      end else begin
        check("data_out hold", 32'(data_out), 32'(last_data));
      end
    end
  end

  initial begin
    do_reset();

    // single three-byte frame
    cycle(1'b1, 8'hA1, 1'b0, 1'b0);
    cycle(1'b1, 8'hA2, 1'b0, 1'b0);
    check("single frame open", 32'(tx_valid_flag), 32'd0);
    cycle(1'b1, 8'hA3, 1'b1, 1'b0);
    check("single frame complete", 32'(tx_valid_flag), 32'd1);
    repeat (3) cycle(1'b0, 8'h00, 1'b0, 1'b1);
    check("single frame drained tx", 32'(tx_valid_flag), 32'd0);
    check("single frame drained empty", 32'(empty), 32'd1);

    // fill, overflow drop, simultaneous at full, drain
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 8'(i), ($urandom_range(0, 63) == 0), 1'b0);
    end
    check("fill full", 32'(full), 32'd1);
    cycle(1'b1, 8'h55, 1'b1, 1'b0);
    cycle(1'b1, 8'h77, 1'b0, 1'b1);
    check("full after rd+wr", 32'(full), 32'd1);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);

    // simultaneous read/write while empty: no fall-through
    cycle(1'b1, 8'h3C, 1'b0, 1'b1);
    check("empty rd+wr not empty", 32'(empty), 32'd0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);

    // advance pointers to just short of the wrap point, then two frames across it
    cycle(1'b1, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 2040; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 1; i <= 5; i++) cycle(1'b1, 8'(8'hC0 + i), (i == 5), (i == 2));
    for (int i = 6; i <= 8; i++) cycle(1'b1, 8'(8'hC0 + i), (i == 8), 1'b0);
    check("two frames held", 32'(tx_valid_flag), 32'd1);
    for (int i = 0; i < 7; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1);
    check("wrap final empty", 32'(empty), 32'd1);
    check("wrap final tx", 32'(tx_valid_flag), 32'd0);

    // random traffic, including a mid-run reset
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 99) < 55), 8'($urandom), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 99) < 50));
      if (i == 1500) do_reset();
    end
    for (int i = 0; i < 40; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1);

    @(posedge clk);
    #1;
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
